// File: rtl/comb_func_pkg.sv
// Shared types and sizes for the comb_func self-test sequencer.
package comb_func_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int TT_W        = 16;
    localparam int ERR_W       = 5;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/comb_func_sweep_ctrl_tt_compare.sv
// Combinational comparison of a captured truth table against the expected one:
// equality, mismatch count and lowest mismatching vector index.
module tt_compare
    import comb_func_pkg::*;
(
    input  logic [TT_W-1:0]  tt,
    input  logic [TT_W-1:0]  exp,
    output logic             eq,
    output logic [ERR_W-1:0] popcount,
    output logic [VEC_W-1:0] low_idx
);

    logic [TT_W-1:0] diff;

    assign diff = tt ^ exp;
    assign eq   = (diff == '0);

    always_comb begin
        popcount = '0;
        for (int i = 0; i < TT_W; i++) begin
            popcount = popcount + ERR_W'(diff[i]);
        end
    end

    // Scan from the top down so the last hit written is the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                low_idx = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/comb_func_sweep_ctrl.sv
// Sweeps all 16 input vectors of comb_func, samples y after a settle time,
// and reports the captured truth table against an expected table.
module comb_func_sweep_ctrl
    import comb_func_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TT_W-1:0]  exp_tt,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  truth_table,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] fail_idx
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : gen_bad_hold
            $error("HOLD_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t           state_reg;
    logic [VEC_W-1:0] v_reg;
    logic [7:0]       cnt_reg;
    logic [TT_W-1:0]  exp_reg;
    logic [VEC_W-1:0] v_next;

    logic             cmp_eq;
    logic [ERR_W-1:0] cmp_popcount;
    logic [VEC_W-1:0] cmp_low_idx;

    assign v_next = v_reg + VEC_W'(1);

    tt_compare u_tt_compare (
        .tt       (truth_table),
        .exp      (exp_reg),
        .eq       (cmp_eq),
        .popcount (cmp_popcount),
        .low_idx  (cmp_low_idx)
    );

    // The vector outputs are registered, so they are updated on the edge that
    // enters APPLY for the next vector (or leaves the sweep).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            v_reg        <= '0;
            cnt_reg      <= '0;
            exp_reg      <= '0;
            {a, b, c, d} <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            truth_table  <= '0;
            pass         <= 1'b0;
            err_cnt      <= '0;
            fail_idx     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= APPLY;
                        v_reg        <= '0;
                        cnt_reg      <= '0;
                        exp_reg      <= exp_tt;
                        {a, b, c, d} <= '0;
                        truth_table  <= '0;
                        pass         <= 1'b0;
                        err_cnt      <= '0;
                        fail_idx     <= '0;
                        busy         <= 1'b1;
                    end
                end
                APPLY: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                SAMPLE: begin
                    truth_table[v_reg] <= y;
                    if (v_reg == VEC_W'(NUM_VECTORS - 1)) begin
                        state_reg    <= CHECK;
                        {a, b, c, d} <= '0;
                    end else begin
                        v_reg        <= v_next;
                        {a, b, c, d} <= v_next;
                        state_reg    <= APPLY;
                    end
                end
                CHECK: begin
                    pass      <= cmp_eq;
                    err_cnt   <= cmp_popcount;
                    fail_idx  <= cmp_low_idx;
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/comb_func_sweep_ctrl.md
Name: comb_func_sweep_ctrl

Overview:
- Self-test sequencer for the 4-input combinational block `comb_func`, which has inputs a, b, c, d and output y.
- Drives all 16 input vectors in order, holds each vector for a programmable settle time, and samples y for each one.
- Builds a 16-bit truth table from the samples and compares it with an expected table.
- Sits beside `comb_func` in the integration top. A start/done handshake lets higher-level test logic run functional checks in-system.

Parameters:
- HOLD_CYCLES, 1, settle cycles each vector is driven before y is sampled. Legal range is 1..255; an elaboration error is raised if it is outside.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sweep request; sampled in IDLE only.
- exp_tt  in  16  expected truth table; bit i is the expected y for vector i. Latched when start is accepted.
- a  out  1  vector bit 3 (MSB) to `comb_func`.
- b  out  1  vector bit 2.
- c  out  1  vector bit 1.
- d  out  1  vector bit 0 (LSB).
- y  in  1  `comb_func` output.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- truth_table  out  16  captured y values; bit i corresponds to vector i = {a,b,c,d}.
- pass  out  1  1 when truth_table == latched exp_tt.
- err_cnt  out  5  popcount(truth_table ^ exp_tt), range 0..16.
- fail_idx  out  4  lowest index i whose bit differs; 0 when there is no mismatch.

Behaviour:
- Reset values: state=IDLE; a, b, c, d = 0; busy = 0; done = 0; truth_table = 0; pass = 0; err_cnt = 0; fail_idx = 0. Internal vector index v = 0, settle count = 0, latched expected table = 0.
- Reset asserted mid-sweep aborts immediately to the reset values. No done pulse is produced and no partial results are kept.
- States: IDLE, APPLY, SAMPLE, CHECK, DONE.
- IDLE:
  - start=1 moves to APPLY.
  - On the same edge: v=0, latch exp_tt, clear truth_table, pass, err_cnt and fail_idx, set busy=1.
- APPLY:
  - {a,b,c,d} = v (a is the MSB).
  - Stays for exactly HOLD_CYCLES cycles, then moves to SAMPLE.
- SAMPLE (1 cycle):
  - The vector is still driven.
  - On the exit edge, truth_table[v] <= y.
  - If v==15, go to CHECK; otherwise v <= v+1 and go to APPLY.
  - v never wraps within a sweep.
- CHECK (1 cycle):
  - Registers pass, err_cnt and fail_idx from truth_table vs the latched exp_tt.
  - Drives {a,b,c,d}=0 and moves to DONE.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next edge moves to IDLE with busy=0.
- Outside APPLY and SAMPLE, a, b, c, d = 0.
- Timing, with the start-accept edge as edge 0:
  - Vector v is applied from edge v*(HOLD_CYCLES+1).
  - CHECK is entered at edge 16*(HOLD_CYCLES+1).
  - done is high for the cycle following edge 16*(HOLD_CYCLES+1)+1. With HOLD_CYCLES=1, that is edge 33.
- start while busy: ignored, no queuing.
- start held high continuously: a new sweep begins from the IDLE cycle after DONE.
- Changing exp_tt mid-sweep has no effect, because the latched copy is used.
- Results hold their values after DONE until the next accepted start.

Decomposition:
- Package `comb_func_pkg`:
  - state enum (IDLE, APPLY, SAMPLE, CHECK, DONE)
  - NUM_VECTORS=16, VEC_W=4, TT_W=16
  - ERR_W=5
- Sub-module `tt_compare`, purely combinational:
  - inputs: 16-bit tt and exp
  - outputs: eq, popcount (5-bit), and lowest-set-bit index (4-bit) of tt^exp
  - instantiated once; its outputs are registered in CHECK.

Test Plan:
- Model y=(a&b)|(c&d), HOLD_CYCLES=1, exp_tt=16'hF888, pulse start -> truth_table=16'hF888, pass=1, err_cnt=0, fail_idx=0, done pulse at edge 33, busy high for edges 1..34.
- Same model, exp_tt=16'hF889 -> pass=0, err_cnt=1, fail_idx=0.
- y stuck at 0, exp_tt=16'hF888 -> truth_table=16'h0000, pass=0, err_cnt=7, fail_idx=3.
- Assert rst at edge 10 of a sweep -> all outputs return to reset values asynchronously, no done pulse; a following start gives a correct full sweep.
- Pulse start again at edge 5 of a running sweep -> ignored; exactly one done pulse, at the same timing.
- HOLD_CYCLES=3, y=a^d -> each vector is held 4 cycles (check a, b, c, d against the expected index per cycle), truth_table=16'h55AA, done at edge 65.
